// File: rtl/alu_muldiv_seq_if.sv
// Request/response and shared-adder signals of the iterative multiply/divide sequencer.
// Signal names match the original port names so existing connections map one-to-one.
interface alu_muldiv_seq_if #(
  parameter int unsigned XLEN = 64
);
  // Execute-stage request side
  logic            req_valid_i;
  logic            req_ready_o;
  logic [1:0]      op_i;
  logic [XLEN-1:0] opa_i;
  logic [XLEN-1:0] opb_i;
  // Result side
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [XLEN-1:0] result_o;
  // Shared adder side
  logic            alu_req_o;
  logic            alu_gnt_i;
  logic [XLEN-1:0] alu_a_o;
  logic [XLEN-1:0] alu_b_o;
  logic            alu_c_o;
  logic [XLEN-1:0] alu_out_i;
  logic            alu_cflag_i;

  // Sequencer view
  modport slave (
    input  req_valid_i, op_i, opa_i, opb_i, rsp_ready_i,
           alu_gnt_i, alu_out_i, alu_cflag_i,
    output req_ready_o, rsp_valid_o, result_o,
           alu_req_o, alu_a_o, alu_b_o, alu_c_o
  );

  // Environment view: execute stage, consumer and adder/arbiter
  modport master (
    output req_valid_i, op_i, opa_i, opb_i, rsp_ready_i,
           alu_gnt_i, alu_out_i, alu_cflag_i,
    input  req_ready_o, rsp_valid_o, result_o,
           alu_req_o, alu_a_o, alu_b_o, alu_c_o
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative MUL / DIVU / REMU sequencer. Runs XLEN add or subtract steps through
// the shared adder, one step per granted cycle, and returns a single result.
module alu_muldiv_seq #(
  parameter int unsigned XLEN = 64
) (
  input logic              clk_i,
  input logic              reset_i,
  alu_muldiv_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REMU = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  // acc_q: product accumulator (MUL) or partial remainder (DIVU/REMU)
  // x_q:   shifted multiplicand (MUL) or dividend/quotient shift register
  // y_q:   shifted multiplier (MUL) or divisor
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] x_q, x_d;
  logic [XLEN-1:0] y_q, y_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic            is_div;
  logic [XLEN-1:0] div_rs;
  logic            div_msb;
  logic            div_ge;
  logic [XLEN-1:0] alu_a, alu_b;
  logic            alu_c;
  logic [XLEN-1:0] acc_step, x_step, y_step;

  // Adder operands and the register values one step would produce; operands depend
  // on state and registers only so no path exists from the adder back into it.
  always_comb begin
    is_div  = (op_q == OP_DIVU) || (op_q == OP_REMU);
    // {div_msb, div_rs} is the XLEN+1-bit shifted remainder {rem, quo[msb]}
    div_msb = acc_q[XLEN-1];
    div_rs  = {acc_q[XLEN-2:0], x_q[XLEN-1]};
    div_ge  = div_msb | bus.alu_cflag_i;

    alu_a = '0;
    alu_b = '0;
    alu_c = 1'b0;
    if (state_q == RUN) begin
      if (is_div) begin
        alu_a = div_rs;
        alu_b = ~y_q;
        alu_c = 1'b1;
      end else begin
        alu_a = acc_q;
        alu_b = x_q & {XLEN{y_q[0]}};
        alu_c = 1'b0;
      end
    end

    if (is_div) begin
      acc_step = div_ge ? bus.alu_out_i : div_rs;
      x_step   = {x_q[XLEN-2:0], div_ge};
      y_step   = y_q;
    end else begin
      acc_step = bus.alu_out_i;
      x_step   = x_q << 1;
      y_step   = y_q >> 1;
    end
  end

  // Sequencer next-state: accept, step on grant, hold result until taken
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    acc_d       = acc_q;
    x_d         = x_q;
    y_d         = y_q;
    result_d    = result_q;
    rsp_valid_d = rsp_valid_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          op_d    = bus.op_i;
          acc_d   = '0;
          x_d     = bus.opa_i;
          y_d     = bus.opb_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.alu_gnt_i) begin
          acc_d = acc_step;
          x_d   = x_step;
          y_d   = y_step;
          if (cnt_q == CW'(XLEN - 1)) begin
            // Final step: capture the result from the post-step values directly
            unique case (op_q)
              OP_DIVU: result_d = x_step;
              OP_REMU: result_d = acc_step;
              default: result_d = acc_step;
            endcase
            rsp_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      y_q         <= y_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.alu_req_o   = (state_q == RUN);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.result_o    = result_q;
  assign bus.alu_a_o     = alu_a;
  assign bus.alu_b_o     = alu_b;
  assign bus.alu_c_o     = alu_c;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: table of MUL/DIVU/REMU vectors through a behavioural
// adder, scoreboard queue of expected results, plus latency, stall, hold and reset cases.
module tb_alu_muldiv_seq;

  localparam int unsigned XLEN = 64;

  logic clk;
  logic rst_n;

  int tests;
  int fails;
  logic [XLEN-1:0] sb_q[$];

  typedef struct {
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    bit              toggle;  // grant alternates 1/0 while running
    bit              hold;    // consumer stalls 5 cycles before taking
  } vec_t;

  alu_muldiv_seq_if #(.XLEN(XLEN)) bus ();

  alu_muldiv_seq #(.XLEN(XLEN)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  // Shared adder: out = a + b + cin, carry out on cflag
  logic [XLEN:0] sum;
  always_comb begin
    sum             = {1'b0, bus.alu_a_o} + {1'b0, bus.alu_b_o} + {{XLEN{1'b0}}, bus.alu_c_o};
    bus.alu_out_i   = sum[XLEN-1:0];
    bus.alu_cflag_i = sum[XLEN];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Drive one request; accept edge lies between the two negedges below
  task automatic send(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [XLEN-1:0] exp, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("req_ready_timeout", {63'd0, bus.req_ready_o}, 64'd1);
      return;
    end
    bus.req_valid_i = 1'b1;
    bus.op_i        = op;
    bus.opa_i       = a;
    bus.opb_i       = b;
    bus.alu_gnt_i   = 1'b1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    sb_q.push_back(exp);
  endtask

  // Wait for rsp_valid; cyc counts edges after the accept edge
  task automatic wait_rsp(input bit toggle, output int cyc, output bit ok, output bit saw_ready);
    cyc       = 0;
    ok        = 1'b0;
    saw_ready = 1'b0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
      if (bus.req_ready_o) saw_ready = 1'b1;
      if (toggle) bus.alu_gnt_i = ~bus.alu_gnt_i;
    end
    bus.alu_gnt_i = 1'b1;
  endtask

  // Take the response; a request offered on the same edge must not be accepted
  task automatic take();
    logic [XLEN-1:0] exp;
    exp = sb_q.pop_front();
    check("result", bus.result_o, exp);
    bus.rsp_ready_i = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.op_i        = 2'b00;
    bus.opa_i       = 64'd3;
    bus.opb_i       = 64'd3;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b0;
    check("rsp_valid_after_take", {63'd0, bus.rsp_valid_o}, 64'd0);
    check("idle_after_take_no_same_edge_req", {63'd0, bus.req_ready_o}, 64'd1);
    check("alu_b_zero_idle", bus.alu_b_o, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t vecs[13];
    bit ok;
    bit saw_ready;
    int cyc;
    logic [XLEN-1:0] held;

    tests = 0;
    fails = 0;
    vecs[0]  = '{2'b00, 64'd7, 64'd6, 64'd42, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b0, 1'b0};
    vecs[3]  = '{2'b01, 64'd100, 64'd7, 64'd14, 1'b0, 1'b1};
    vecs[4]  = '{2'b10, 64'd100, 64'd7, 64'd2, 1'b0, 1'b0};
    vecs[5]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b0};
    vecs[7]  = '{2'b01, 64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[8]  = '{2'b10, 64'd1234, 64'd0, 64'h4D2, 1'b0, 1'b0};
    vecs[9]  = '{2'b01, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 1'b0};
    vecs[11] = '{2'b11, 64'h1234_5678, 64'h9ABC, 64'h1234_5678 * 64'h9ABC, 1'b1, 1'b0};
    vecs[12] = '{2'b01, 64'd1000000, 64'd37, 64'd27027, 1'b1, 1'b0};

    bus.req_valid_i = 1'b0;
    bus.op_i        = '0;
    bus.opa_i       = '0;
    bus.opb_i       = '0;
    bus.rsp_ready_i = 1'b0;
    bus.alu_gnt_i   = 1'b1;
    do_reset();

    check("reset_req_ready", {63'd0, bus.req_ready_o}, 64'd1);
    check("reset_rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    check("reset_alu_req", {63'd0, bus.alu_req_o}, 64'd0);
    check("reset_alu_a", bus.alu_a_o, 64'd0);

    for (int v = 0; v < 13; v++) begin
      send(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].exp, ok);
      if (!ok) begin
        do_reset();
        continue;
      end
      check("alu_req_in_run", {63'd0, bus.alu_req_o}, 64'd1);
      wait_rsp(vecs[v].toggle, cyc, ok, saw_ready);
      if (!ok) begin
        check("rsp_timeout", {63'd0, bus.rsp_valid_o}, 64'd1);
        do_reset();
        continue;
      end
      check("ready_low_while_busy", {63'd0, saw_ready}, 64'd0);
      // Latency counted from the accept edge inclusive
      if (v == 0) check("latency_continuous_grant", 64'(cyc + 1), 64'd65);
      if (vecs[v].toggle) begin
        tests++;
        if (cyc + 1 < 127 || cyc + 1 > 131) begin
          fails++;
          $display("FAIL latency_toggled_grant: got %0d cycles, expected 127..131", cyc + 1);
        end
      end
      if (vecs[v].hold) begin
        held = bus.result_o;
        repeat (5) @(negedge clk);
        check("hold_rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
        check("hold_result", bus.result_o, held);
      end
      take();
    end

    // Reset in the middle of a run discards the operation
    send(2'b00, 64'd7, 64'd6, 64'd42, ok);
    if (ok) begin
      repeat (30) @(negedge clk);
      check("mid_run_alu_req", {63'd0, bus.alu_req_o}, 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      void'(sb_q.pop_front());
      check("mid_run_reset_ready", {63'd0, bus.req_ready_o}, 64'd1);
      check("mid_run_reset_rsp_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
      check("mid_run_reset_alu_req", {63'd0, bus.alu_req_o}, 64'd0);
      repeat (3) @(negedge clk);
      check("no_rsp_after_reset", {63'd0, bus.rsp_valid_o}, 64'd0);
    end
    send(2'b10, 64'd100, 64'd7, 64'd2, ok);
    if (ok) begin
      wait_rsp(1'b0, cyc, ok, saw_ready);
      if (ok) take();
      else check("rsp_timeout_post_reset", {63'd0, bus.rsp_valid_o}, 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
